// File: rtl/apb_slv_regbank.sv
// apb_slv_regbank: APB4 slave register bank with byte strobes and PSLVERR.
// Register 0 is a read-only ID word. Registers 1..DEPTH-1 are read/write.
// Define APB_SLV_WAIT_EN to build the WAIT state and its counter, which insert
// WAIT_CYCLES wait states. Without it every transfer is zero-wait.
module apb_slv_regbank #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((1 << OFFS) - 1);
  localparam logic [DATA_WIDTH-1:0] ID_WORD   = DATA_WIDTH'(ID_VALUE);

`ifdef APB_SLV_WAIT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_READY = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READY = 2'd2} state_e;
`endif

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
`ifdef APB_SLV_WAIT_EN
  logic [3:0]              cnt_q, cnt_d;
`endif
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

  logic                    setup;
  logic                    access_ok;
  logic [IDX_W-1:0]        idx;
  logic                    misalign;
  logic                    out_of_range;
  logic                    err;
  logic                    ready;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign setup     = PSELx & ~PENABLE;
  assign access_ok = PSELx & PENABLE;

  // Decode of the latched address: word index and error classification.
  assign idx          = IDX_W'(addr_q >> OFFS);
  assign misalign     = (addr_q & OFFS_MASK) != '0;
  assign out_of_range = (addr_q >> (OFFS + IDX_W)) != '0;
  assign err          = misalign | out_of_range | (write_q & (idx == '0));

  assign ready   = (state_q == ST_READY);
  assign wr_en   = ready & access_ok & write_q & ~err;
  assign rd_word = (idx == '0) ? ID_WORD : regs_q[idx];

  assign PREADY  = ready;
  assign PSLVERR = ready & err;
  assign PRDATA  = (ready & ~write_q & ~err) ? rd_word : '0;

  // State, latched request and wait counter registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
`ifdef APB_SLV_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic: latch on setup, count wait states, abort on dropped select.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
`ifdef APB_SLV_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          addr_d  = PADDR;
          write_d = PWRITE;
`ifdef APB_SLV_WAIT_EN
          if (WAIT_CYCLES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_READY;
          end
`else
          state_d = ST_READY;
`endif
        end
      end
`ifdef APB_SLV_WAIT_EN
      ST_WAIT: begin
        if (!access_ok) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      ST_READY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Register array: per-lane update from live PWDATA on the completing edge.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (PSTRB[b]) begin
          regs_q[idx][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slv_regbank.sv
// tb_apb_slv_regbank: directed and randomized APB transfers against a word-array model.
module tb_apb_slv_regbank;

`ifdef APB_SLV_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif
  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        clk, rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mdl [16];

  apb_slv_regbank dut (
    .PCLK(clk), .PRESET(rst), .PSELx(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: error rule and read value from the word address.
  function automatic logic exp_err(input logic wr, input logic [7:0] a);
    int unsigned i;
    i = int'(a) / 4;
    return ((int'(a) % 4) != 0) || (i >= 16) || (wr && i == 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic wr, input logic [7:0] a);
    int unsigned i;
    i = int'(a) / 4;
    if (wr || exp_err(wr, a)) return 32'h0;
    if (i == 0) return ID;
    return mdl[i];
  endfunction

  task automatic mdl_write(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned i;
    i = int'(a) / 4;
    if (wr && !exp_err(wr, a))
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
  endtask

  // One APB transfer, entered and left just after a rising edge.
  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic er, output int acc);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1; acc = 0; rd = 32'h0; er = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (pready) begin
        acc = c; rd = prdata; er = pslverr;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int acc;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    mdl_clear();
    #3;
    n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b exp 0", pready); end
    n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h exp 0", prdata); end
    n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b exp 0", pslverr); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      apb_xfer(1'b0, 8'(i * 4), 32'h0, 4'h0, rd, er, acc);
      n_checks++; if (rd !== exp_rd(1'b0, 8'(i * 4))) begin n_fail++; $display("FAIL reset_read[%0d]: got %h exp %h", i, rd, exp_rd(1'b0, 8'(i * 4))); end
    end
  endtask

  task automatic test_full_write_read();
    logic [31:0] rd; logic er; int acc;
    apb_xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, er, acc); mdl_write(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    n_checks++; if (acc !== 1 + W) begin n_fail++; $display("FAIL full_wr_latency: got %0d exp %0d", acc, 1 + W); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL full_wr_err: got %b exp 0", er); end
    apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, er, acc);
    n_checks++; if (acc !== 1 + W) begin n_fail++; $display("FAIL full_rd_latency: got %0d exp %0d", acc, 1 + W); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_rd_data: got %h exp DEADBEEF", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL full_rd_err: got %b exp 0", er); end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] rd; logic er; int acc;
    apb_xfer(1'b1, 8'h04, 32'h11223344, 4'b0101, rd, er, acc); mdl_write(1'b1, 8'h04, 32'h11223344, 4'b0101);
    apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, er, acc);
    n_checks++; if (rd !== 32'hDE22BE44) begin n_fail++; $display("FAIL partial_rd_data: got %h exp DE22BE44", rd); end
  endtask

  task automatic test_error_addr();
    logic [31:0] rd; logic er; int acc;
    apb_xfer(1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, rd, er, acc);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_wr_range: got %b exp 1", er); end
    apb_xfer(1'b0, 8'h40, 32'h0, 4'hF, rd, er, acc);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_rd_range: got %b exp 1", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_rd_data: got %h exp 0", rd); end
    apb_xfer(1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, rd, er, acc);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_wr_misalign: got %b exp 1", er); end
    apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, er, acc);
    n_checks++; if (rd !== 32'hDE22BE44) begin n_fail++; $display("FAIL err_no_change: got %h exp DE22BE44", rd); end
  endtask

  task automatic test_id_reg();
    logic [31:0] rd; logic er; int acc;
    apb_xfer(1'b1, 8'h00, 32'hFFFFFFFF, 4'hF, rd, er, acc);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL id_wr_err: got %b exp 1", er); end
    apb_xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, er, acc);
    n_checks++; if (rd !== ID) begin n_fail++; $display("FAIL id_rd_data: got %h exp %h", rd, ID); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL id_rd_err: got %b exp 0", er); end
  endtask

  task automatic test_abort_reset();
    logic [31:0] rd; logic er; int acc;
    apb_xfer(1'b1, 8'h08, 32'hCAFEF00D, 4'hF, rd, er, acc); mdl_write(1'b1, 8'h08, 32'hCAFEF00D, 4'hF);
    // Select dropped right after the setup phase.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1;
    psel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL abort_pready: got %b exp 0", pready); end
    n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL abort_pslverr: got %b exp 0", pslverr); end
    @(posedge clk); #1;
    apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, er, acc);
    n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort_rd_data: got %h exp CAFEF00D", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL abort_rd_err: got %b exp 0", er); end
    // Reset asserted in the first access cycle of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h55AA55AA; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pready: got %b exp 0", pready); end
    n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_prdata: got %h exp 0", prdata); end
    n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pslverr: got %b exp 0", pslverr); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; rst = 1'b0;
    mdl_clear();
    for (int i = 1; i < 16; i++) begin
      apb_xfer(1'b0, 8'(i * 4), 32'h0, 4'h0, rd, er, acc);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_clear[%0d]: got %h exp 0", i, rd); end
    end
    apb_xfer(1'b1, 8'h0C, 32'h0BADCAFE, 4'hF, rd, er, acc); mdl_write(1'b1, 8'h0C, 32'h0BADCAFE, 4'hF);
    n_checks++; if (acc !== 1 + W) begin n_fail++; $display("FAIL rst_after_latency: got %0d exp %0d", acc, 1 + W); end
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, er, acc);
    n_checks++; if (rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL rst_after_rd: got %h exp 0BADCAFE", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, d; logic er; int acc_w, acc_r; time t0, t1;
    d = $urandom;
    t0 = $time;
    apb_xfer(1'b1, 8'h0C, d, 4'hF, rd, er, acc_w); mdl_write(1'b1, 8'h0C, d, 4'hF);
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, er, acc_r);
    t1 = $time;
    n_checks++; if (acc_w !== 1 + W) begin n_fail++; $display("FAIL b2b_wr_latency: got %0d exp %0d", acc_w, 1 + W); end
    n_checks++; if (acc_r !== 1 + W) begin n_fail++; $display("FAIL b2b_rd_latency: got %0d exp %0d", acc_r, 1 + W); end
    n_checks++; if (rd !== d) begin n_fail++; $display("FAIL b2b_raw_data: got %h exp %h", rd, d); end
    n_checks++; if ((t1 - t0) !== time'(2 * (2 + W) * 10)) begin n_fail++; $display("FAIL b2b_duration: got %0t exp %0d", t1 - t0, 2 * (2 + W) * 10); end
    @(negedge clk);
    n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL b2b_post_pready: got %b exp 0", pready); end
    n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL b2b_post_prdata: got %h exp 0", prdata); end
    n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL b2b_post_pslverr: got %b exp 0", pslverr); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] rd, d; logic er, wr; int acc; logic [7:0] a; logic [3:0] s; int r;
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 8'($urandom_range(0, 15) * 4);
      else if (r == 7) a = 8'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             a = 8'($urandom_range(64, 255));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      apb_xfer(wr, a, d, s, rd, er, acc);
      n_checks++; if (acc !== 1 + W) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d exp %0d", n, acc, 1 + W); end
      n_checks++; if (er !== exp_err(wr, a)) begin n_fail++; $display("FAIL rnd_err[%0d] a=%h wr=%b: got %b exp %b", n, a, wr, er, exp_err(wr, a)); end
      n_checks++; if (rd !== exp_rd(wr, a)) begin n_fail++; $display("FAIL rnd_rdata[%0d] a=%h wr=%b: got %h exp %h", n, a, wr, rd, exp_rd(wr, a)); end
      mdl_write(wr, a, d, s);
    end
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_partial_strobe();
    test_error_addr();
    test_id_reg();
    test_abort_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
